// File: rtl/uart_pkg.sv
// Shared UART definitions: frame geometry, receiver state encoding, parity convention.
package uart_pkg;

  localparam int unsigned UART_DATA_BITS  = 8;
  localparam int unsigned UART_OVERSAMPLE = 16;

  // Receiver FSM states.
  typedef enum logic [2:0] {
    StIdle     = 3'd0,
    StStart    = 3'd1,
    StData     = 3'd2,
    StParity   = 3'd3,
    StStop     = 3'd4,
    StWaitHigh = 3'd5
  } uart_rx_state_e;

  // Even parity: the parity bit makes the XOR of data and parity equal 0.
  function automatic logic even_parity_bit(input logic [UART_DATA_BITS-1:0] data);
    return ^data;
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the serial line plus a registered falling-edge pulse
// aligned with the synchronized output.
module uart_rx_sync (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic rx_i,
  output logic rx_s_o,
  output logic fall_o
);

  logic meta_q, rx_s_q, fall_q;
  logic fall_d;

  // Edge fires in the same cycle rx_s first reads 0 after a 1.
  always_comb begin
    fall_d = rx_s_q & ~meta_q;
  end

  // Synchronizer flops idle high so reset never looks like a start edge.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= 1'b1;
      rx_s_q <= 1'b1;
      fall_q <= 1'b0;
    end else begin
      meta_q <= rx_i;
      rx_s_q <= meta_q;
      fall_q <= fall_d;
    end
  end

  assign rx_s_o = rx_s_q;
  assign fall_o = fall_q;

endmodule

// File: rtl/uart_rx.sv
// UART receiver: start, 8 data bits LSB first, optional even parity, one stop bit,
// 2-of-3 majority vote around mid-bit.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned OVERSAMPLE = UART_OVERSAMPLE,
  parameter bit          PARITY_EN  = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] dataout,
  output logic       rdsig,
  output logic       parity_err,
  output logic       frame_err,
  output logic       busy
);

  localparam int unsigned CntW = $clog2(OVERSAMPLE);
  localparam int unsigned IdxW = $clog2(UART_DATA_BITS);
  localparam int unsigned Half = OVERSAMPLE / 2;
  localparam logic [CntW-1:0] CntS0   = CntW'(Half - 1);
  localparam logic [CntW-1:0] CntS1   = CntW'(Half);
  localparam logic [CntW-1:0] CntDec  = CntW'(Half + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(OVERSAMPLE - 1);
  localparam logic [IdxW-1:0] IdxLast = IdxW'(UART_DATA_BITS - 1);

  logic rx_s, fall;

  uart_rx_sync u_sync (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .rx_i   (rx),
    .rx_s_o (rx_s),
    .fall_o (fall)
  );

  uart_rx_state_e state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [IdxW-1:0] bit_idx_q, bit_idx_d;
  logic [UART_DATA_BITS-1:0] shift_q, shift_d;
  logic [1:0] samp_q, samp_d;
  logic par_err_q, par_err_d;
  logic [7:0] dataout_q, dataout_d;
  logic rdsig_q, rdsig_d, parity_err_q, parity_err_d;
  logic frame_err_q, frame_err_d, busy_q, busy_d;
  logic vote, in_bit, cnt_last, at_dec;

  // Majority of the samples at Half-1, Half and the current one at Half+1.
  assign vote     = (samp_q[1] & samp_q[0]) | (samp_q[1] & rx_s) | (samp_q[0] & rx_s);
  assign in_bit   = (state_q == StStart) || (state_q == StData) ||
                    (state_q == StParity) || (state_q == StStop);
  assign cnt_last = (cnt_q == CntLast);
  assign at_dec   = (cnt_q == CntDec);

  // Next-state and registered-output computation.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    bit_idx_d    = bit_idx_q;
    shift_d      = shift_q;
    samp_d       = samp_q;
    par_err_d    = par_err_q;
    dataout_d    = dataout_q;
    rdsig_d      = 1'b0;
    parity_err_d = parity_err_q;
    frame_err_d  = frame_err_q;
    busy_d       = busy_q;

    if (in_bit) begin
      cnt_d = cnt_last ? '0 : cnt_q + CntW'(1);
      if (cnt_q == CntS0) samp_d[1] = rx_s;
      if (cnt_q == CntS1) samp_d[0] = rx_s;
    end

    unique case (state_q)
      StIdle: begin
        if (fall) begin
          state_d   = StStart;
          // The edge cycle itself is sub-sample 0 of the start bit.
          cnt_d     = CntW'(1);
          bit_idx_d = '0;
          busy_d    = 1'b1;
        end
      end
      StStart: begin
        if (at_dec && vote) begin
          state_d = StIdle;
          cnt_d   = '0;
          busy_d  = 1'b0;
        end else if (cnt_last) begin
          state_d = StData;
        end
      end
      StData: begin
        if (at_dec) shift_d[bit_idx_q] = vote;
        if (cnt_last) begin
          bit_idx_d = bit_idx_q + IdxW'(1);
          if (bit_idx_q == IdxLast) state_d = PARITY_EN ? StParity : StStop;
        end
      end
      StParity: begin
        if (at_dec) par_err_d = even_parity_bit(shift_q) ^ vote;
        if (cnt_last) state_d = StStop;
      end
      StStop: begin
        if (at_dec) begin
          dataout_d    = shift_q;
          parity_err_d = PARITY_EN ? par_err_q : 1'b0;
          frame_err_d  = ~vote;
          rdsig_d      = 1'b1;
          cnt_d        = '0;
          // Good stop returns early so a back-to-back start edge is caught.
          if (vote) begin
            state_d = StIdle;
            busy_d  = 1'b0;
          end else begin
            state_d = StWaitHigh;
          end
        end
      end
      StWaitHigh: begin
        if (rx_s) begin
          state_d = StIdle;
          busy_d  = 1'b0;
        end
      end
      default: begin
        state_d = StIdle;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      bit_idx_q    <= '0;
      shift_q      <= '0;
      samp_q       <= '0;
      par_err_q    <= 1'b0;
      dataout_q    <= '0;
      rdsig_q      <= 1'b0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      bit_idx_q    <= bit_idx_d;
      shift_q      <= shift_d;
      samp_q       <= samp_d;
      par_err_q    <= par_err_d;
      dataout_q    <= dataout_d;
      rdsig_q      <= rdsig_d;
      parity_err_q <= parity_err_d;
      frame_err_q  <= frame_err_d;
      busy_q       <= busy_d;
    end
  end

  assign dataout    = dataout_q;
  assign rdsig      = rdsig_q;
  assign parity_err = parity_err_q;
  assign frame_err  = frame_err_q;
  assign busy       = busy_q;

endmodule
